// File: rtl/uart_mem_bridge_if.sv
// CPU load/store port and UART byte-stream port of the UART memory bridge.
interface uart_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              write_enable;
  logic              read_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_done;
  logic              mem_err;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;

  // bridge side
  modport slave (
    input  write_enable, read_enable, address, write_data, tx_ready, rx_data, rx_valid,
    output read_data, mem_done, mem_err, busy, tx_data, tx_valid
  );

  // CPU / UART side
  modport master (
    output write_enable, read_enable, address, write_data, tx_ready, rx_data, rx_valid,
    input  read_data, mem_done, mem_err, busy, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Serialises CPU loads/stores into framed UART byte sequences and collects
// the response, with response timeout and bounded re-send on NAK/timeout.
//
// state     | meaning
// IDLE      | waiting for a load/store request
// SEND_CMD  | presenting 'W' or 'R' command byte
// SEND_ADDR | presenting address bytes, MSB first
// SEND_DATA | presenting store data bytes, MSB first
// WAIT_ACK  | waiting for ACK/NAK after a store frame
// RECV_DATA | collecting load data bytes, MSB first
// DONE      | one-cycle completion pulse, mem_err qualifies it
module uart_mem_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAX_RETRY   = 2
) (
  input  logic            clk,
  input  logic            reset,
  uart_mem_bridge_if.slave bus
);

  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam int MAX_B  = (ADDR_B > DATA_B) ? ADDR_B : DATA_B;
  localparam int BCW    = $clog2(MAX_B) + 1;
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FW     = ADDR_W + DATA_W;

  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_B - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_B - 1);
  localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYC);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]     CMD_WR    = 8'h57;
  localparam logic [7:0]     CMD_RD    = 8'h52;
  localparam logic [7:0]     ACK_BYTE  = 8'h06;

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_ACK, RECV_DATA, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [FW-1:0]     sh_q, sh_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tx_valid_c;
  logic [7:0]        tx_data_c;
  logic              retry_req;

  // state and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sh_q       <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      retry_q    <= '0;
      rx_sh_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sh_q       <= sh_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      retry_q    <= retry_d;
      rx_sh_q    <= rx_sh_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // next-state, frame serialisation, response collection and retry decision
  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sh_d       = sh_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    retry_d    = retry_q;
    rx_sh_d    = rx_sh_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    retry_req  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.write_enable || bus.read_enable) begin
          op_wr_d = bus.write_enable;
          addr_d  = bus.address;
          wdata_d = bus.write_data;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD: begin
        tx_valid_c = 1'b1;
        tx_data_c  = op_wr_q ? CMD_WR : CMD_RD;
        if (bus.tx_ready) begin
          // address and store data share one shift register, address on top
          sh_d       = {addr_q, wdata_q};
          byte_cnt_d = '0;
          state_d    = SEND_ADDR;
        end
      end
      SEND_ADDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = sh_q[FW-1 -: 8];
        if (bus.tx_ready) begin
          sh_d = sh_q << 8;
          if (byte_cnt_q == ADDR_LAST) begin
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            rx_sh_d    = '0;
            state_d    = op_wr_q ? SEND_DATA : RECV_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      SEND_DATA: begin
        tx_valid_c = 1'b1;
        tx_data_c  = sh_q[FW-1 -: 8];
        if (bus.tx_ready) begin
          sh_d = sh_q << 8;
          if (byte_cnt_q == DATA_LAST) begin
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = WAIT_ACK;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      WAIT_ACK: begin
        if (bus.rx_valid) begin
          tmo_cnt_d = '0;
          if (bus.rx_data == ACK_BYTE) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            retry_req = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          retry_req = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      RECV_DATA: begin
        if (bus.rx_valid) begin
          tmo_cnt_d = '0;
          rx_sh_d   = (rx_sh_q << 8) | DATA_W'(bus.rx_data);
          if (byte_cnt_q == DATA_LAST) begin
            rdata_d = rx_sh_d;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          retry_req = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // re-send the whole frame from the latched request, or give up
    if (retry_req) begin
      if (retry_q < RETRY_MAX) begin
        retry_d    = retry_q + RW'(1);
        rx_sh_d    = '0;
        byte_cnt_d = '0;
        tmo_cnt_d  = '0;
        state_d    = SEND_CMD;
      end else begin
        err_d   = 1'b1;
        state_d = DONE;
        if (!op_wr_q) rdata_d = '0;
      end
    end
  end

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.read_data = rdata_q;
  assign bus.mem_done  = (state_q == DONE);
  assign bus.mem_err   = (state_q == DONE) && err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: a 32/32 instance for framing, retry,
// timeout and reset scenarios, and a 16/16 instance with a throttled transmitter.
module tb_uart_mem_bridge;

  logic clk = 1'b0;
  logic rst_n;
  bit   tog_b = 1'b0;
  int   cyc = 0;

  int tests = 0;
  int fails = 0;

  uart_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  uart_mem_bridge_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  uart_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(50), .MAX_RETRY(2)) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a)
  );
  uart_mem_bridge #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(50), .MAX_RETRY(2)) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // transmitter ready for instance B: constant or toggling every cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    bus_b.tx_ready = tog_b ? cyc[0] : 1'b1;
  end

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          done_cnt_a = 0, done_cnt_b = 0;
  logic [31:0] last_rd_a;
  logic [15:0] last_rd_b;
  logic        last_err_a, last_err_b;
  logic        prev_done_a = 1'b0, prev_done_b = 1'b0;
  int          pw_viol = 0, err_viol = 0, hold_viol_b = 0;
  logic        stall_b = 1'b0;
  logic [7:0]  hold_data_b = 8'h00;

  // monitor A: accepted tx bytes, completion info, pulse shape
  always @(negedge clk) begin
    if (bus_a.tx_valid && bus_a.tx_ready) q_a.push_back(bus_a.tx_data);
    if (bus_a.mem_done) begin
      done_cnt_a++;
      last_rd_a  = bus_a.read_data;
      last_err_a = bus_a.mem_err;
    end
    if (bus_a.mem_done && prev_done_a) pw_viol++;
    if (bus_a.mem_err && !bus_a.mem_done) err_viol++;
    prev_done_a = bus_a.mem_done;
  end

  // monitor B: same, plus tx byte must hold while the transmitter stalls
  always @(negedge clk) begin
    if (stall_b && (!bus_b.tx_valid || bus_b.tx_data !== hold_data_b)) hold_viol_b++;
    stall_b     = bus_b.tx_valid && !bus_b.tx_ready;
    hold_data_b = bus_b.tx_data;
    if (bus_b.tx_valid && bus_b.tx_ready) q_b.push_back(bus_b.tx_data);
    if (bus_b.mem_done) begin
      done_cnt_b++;
      last_rd_b  = bus_b.read_data;
      last_err_b = bus_b.mem_err;
    end
    if (bus_b.mem_done && prev_done_b) pw_viol++;
    if (bus_b.mem_err && !bus_b.mem_done) err_viol++;
    prev_done_b = bus_b.mem_done;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input bit b);
    return b ? q_b.size() : q_a.size();
  endfunction

  task automatic wait_q(input bit b, input int n, input string tag);
    int k = 0;
    while (qsize(b) < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (qsize(b) < n) chk({tag, " tx count"}, 64'(qsize(b)), 64'(n));
  endtask

  task automatic wait_done(input bit b, input int start, input string tag, output int cycles);
    int k = 0;
    while ((b ? done_cnt_b : done_cnt_a) == start && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    cycles = k;
    chk({tag, " done count"}, 64'(b ? done_cnt_b : done_cnt_a), 64'(start + 1));
  endtask

  task automatic rx(input bit b, input logic [7:0] d);
    if (b) begin bus_b.rx_data = d; bus_b.rx_valid = 1'b1; end
    else   begin bus_a.rx_data = d; bus_a.rx_valid = 1'b1; end
    @(posedge clk); #1;
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  task automatic chk_bytes(input bit b, input int off, input logic [7:0] ex[$], input string tag);
    chk({tag, " len"}, 64'(qsize(b) >= off + ex.size()), 64'(1));
    for (int i = 0; i < ex.size(); i++) begin
      if (off + i < qsize(b))
        chk($sformatf("%s[%0d]", tag, off + i), b ? q_b[off+i] : q_a[off+i], ex[i]);
    end
  endtask

  initial begin
    logic [7:0] ex[$];
    int d0, cycles;

    rst_n = 1'b0;
    bus_a.write_enable = 0; bus_a.read_enable = 0; bus_a.address = '0; bus_a.write_data = '0;
    bus_a.tx_ready = 1'b1;  bus_a.rx_data = '0;    bus_a.rx_valid = 0;
    bus_b.write_enable = 0; bus_b.read_enable = 0; bus_b.address = '0; bus_b.write_data = '0;
    bus_b.rx_data = '0;     bus_b.rx_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst read_data", bus_a.read_data, 0);
    chk("rst mem_done", bus_a.mem_done, 0);
    chk("rst mem_err", bus_a.mem_err, 0);
    chk("rst busy", bus_a.busy, 0);
    chk("rst tx_valid", bus_a.tx_valid, 0);
    chk("rst tx_data", bus_a.tx_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write 0xDEADBEEF to 0x10, ACK
    q_a.delete(); d0 = done_cnt_a;
    bus_a.address = 32'h0000_0010; bus_a.write_data = 32'hDEAD_BEEF; bus_a.write_enable = 1;
    @(posedge clk); #1;
    chk("t1 busy", bus_a.busy, 1);
    wait_q(0, 9, "t1");
    rx(0, 8'h06);
    wait_done(0, d0, "t1", cycles);
    bus_a.write_enable = 0;
    chk("t1 mem_err", last_err_a, 0);
    ex = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    chk_bytes(0, 0, ex, "t1 tx");

    // 2: read 0x20, reply 12 34 56 78
    q_a.delete(); d0 = done_cnt_a;
    bus_a.address = 32'h0000_0020; bus_a.read_enable = 1;
    wait_q(0, 5, "t2");
    rx(0, 8'h12); rx(0, 8'h34); rx(0, 8'h56); rx(0, 8'h78);
    wait_done(0, d0, "t2", cycles);
    bus_a.read_enable = 0;
    chk("t2 read_data", last_rd_a, 32'h1234_5678);
    chk("t2 mem_err", last_err_a, 0);
    ex = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    chk_bytes(0, 0, ex, "t2 tx");

    // 3: stray ACK while idle is dropped; NAK then ACK resends the frame
    rx(0, 8'h06);
    @(posedge clk); #1;
    chk("t3 idle busy", bus_a.busy, 0);
    q_a.delete(); d0 = done_cnt_a;
    bus_a.address = 32'h0000_0044; bus_a.write_data = 32'h0102_0304; bus_a.write_enable = 1;
    wait_q(0, 9, "t3a");
    rx(0, 8'h15);
    wait_q(0, 18, "t3b");
    rx(0, 8'h06);
    wait_done(0, d0, "t3", cycles);
    bus_a.write_enable = 0;
    chk("t3 mem_err", last_err_a, 0);
    chk("t3 byte total", q_a.size(), 18);
    ex = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04};
    chk_bytes(0, 0, ex, "t3 tx1");
    chk_bytes(0, 9, ex, "t3 tx2");

    // 4: read with no reply exhausts retries
    q_a.delete(); d0 = done_cnt_a;
    bus_a.address = 32'h0000_0030; bus_a.read_enable = 1;
    wait_q(0, 5, "t4");
    wait_done(0, d0, "t4", cycles);
    bus_a.read_enable = 0;
    chk("t4 mem_err", last_err_a, 1);
    chk("t4 read_data", last_rd_a, 0);
    chk("t4 byte total", q_a.size(), 15);
    ex = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30};
    chk_bytes(0, 10, ex, "t4 tx3");
    chk("t4 latency >=150", 64'(cycles >= 150), 1);
    chk("t4 latency <=200", 64'(cycles <= 200), 1);
    @(posedge clk); #1;
    chk("t4 err cleared", bus_a.mem_err, 0);

    // 5: reset during the address phase, then a fresh write (write wins)
    q_a.delete(); d0 = done_cnt_a;
    bus_a.address = 32'h1020_3040; bus_a.write_data = 32'h1122_3344; bus_a.write_enable = 1;
    wait_q(0, 2, "t5a");
    chk("t5 busy before rst", bus_a.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 rst tx_valid", bus_a.tx_valid, 0);
    chk("t5 rst busy", bus_a.busy, 0);
    bus_a.write_enable = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5 no done", done_cnt_a, d0);
    q_a.delete();
    bus_a.address = 32'h0000_0008; bus_a.write_data = 32'hCAFE_F00D;
    bus_a.write_enable = 1; bus_a.read_enable = 1;
    wait_q(0, 9, "t5b");
    rx(0, 8'h06);
    wait_done(0, d0, "t5", cycles);
    bus_a.write_enable = 0; bus_a.read_enable = 0;
    chk("t5 mem_err", last_err_a, 0);
    ex = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    chk_bytes(0, 0, ex, "t5 tx");

    // 6: 16/16 instance, throttled transmitter, read 0x0004 -> 0xABCD
    tog_b = 1'b1;
    q_b.delete(); d0 = done_cnt_b;
    bus_b.address = 16'h0004; bus_b.read_enable = 1;
    wait_q(1, 3, "t6");
    rx(1, 8'hAB); rx(1, 8'hCD);
    wait_done(1, d0, "t6", cycles);
    bus_b.read_enable = 0;
    chk("t6 read_data", last_rd_b, 16'hABCD);
    chk("t6 mem_err", last_err_b, 0);
    ex = '{8'h52, 8'h00, 8'h04};
    chk_bytes(1, 0, ex, "t6 tx");
    chk("t6 tx hold", hold_viol_b, 0);

    chk("done pulse width", pw_viol, 0);
    chk("mem_err outside done", err_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
